// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types for the bit-serial adder controller: FSM state encoding and default width.
package serial_adder_ctrl_pkg;

  localparam int SA_DEFAULT_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// One-bit full adder used once per RUN cycle by the serial controller.
module sa_fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one bit pair per RUN cycle through a single full-adder cell, LSB first.
// Define SERIAL_ADD_SUB_EN to add the sub port (a - b via inverted b and forced carry-in).
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int N = SA_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int CW = $clog2(N) + 1;

  sa_state_t     state, state_nxt;
  logic [N-1:0]  opa, opb, acc, b_in;
  logic [CW-1:0] cnt;
  logic          cy, c_in, fs, fco, last;

`ifdef SERIAL_ADD_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub | cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  sa_fa_cell u_fa (.x(opa[0]), .y(opb[0]), .ci(cy), .s(fs), .co(fco));

  assign last = (cnt == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result lands in sum/cout only on the final bit so the outputs stay frozen during RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa  <= '0;
      opb  <= '0;
      acc  <= '0;
      cy   <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          opa <= a;
          opb <= b_in;
          cy  <= c_in;
          cnt <= '0;
        end
        RUN: begin
          opa <= opa >> 1;
          opb <= opb >> 1;
          cy  <= fco;
          acc <= {fs, acc[N-1:1]};
          if (last) begin
            sum  <= {fs, acc[N-1:1]};
            cout <= fco;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
